// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// The HAZARD_PERF_CNT_EN build option adds performance counters in the top.
package hazard_controller_pkg;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned PERF_W = 32;
   localparam int unsigned NEED_W = 2;

   localparam logic [REG_AW-1:0] X0 = 5'd0;

   // Stall cycles still required by the instruction in ID
   localparam logic [NEED_W-1:0] NEED_NONE = 2'd0;
   localparam logic [NEED_W-1:0] NEED_ONE  = 2'd1;
   localparam logic [NEED_W-1:0] NEED_TWO  = 2'd2;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } state_e;

   // x0 is hardwired to zero, so it never creates a dependency
   function automatic logic rd_match(input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs1,
                                     input logic [REG_AW-1:0] rs2,
                                     input logic              use_rs1,
                                     input logic              use_rs2);
      return (rd != X0) && ((use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2)));
   endfunction

endpackage

// File: rtl/hazard_controller_hazard_detect.sv
// Combinational hazard classifier: how many stall cycles the ID instruction
// needs beyond what operand forwarding can cover.
module hazard_detect
   import hazard_controller_pkg::*;
(
   input  logic [REG_AW-1:0] i_id_rs1,
   input  logic [REG_AW-1:0] i_id_rs2,
   input  logic              i_id_use_rs1,
   input  logic              i_id_use_rs2,
   input  logic              i_id_branch,
   input  logic              i_id_jalr,
   input  logic [REG_AW-1:0] i_id_ex_rd,
   input  logic              i_id_ex_regwrite,
   input  logic              i_id_ex_memread,
   input  logic [REG_AW-1:0] i_ex_mem_rd,
   input  logic              i_ex_mem_memread,
   output logic [NEED_W-1:0] o_need
);

   logic w_ctl;
   logic w_id_ex_match;
   logic w_ex_mem_match;

   assign w_ctl          = i_id_branch | i_id_jalr;
   assign w_id_ex_match  = rd_match(i_id_ex_rd, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2);
   assign w_ex_mem_match = rd_match(i_ex_mem_rd, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2);

   // Branch compare in ID needs operands a full stage earlier than EX does
   always_comb begin
      o_need = NEED_NONE;
      if (w_ctl && i_id_ex_memread && w_id_ex_match) begin
         o_need = NEED_TWO;
      end else if ((w_ctl && i_id_ex_regwrite && w_id_ex_match) ||
                   (w_ctl && i_ex_mem_memread && w_ex_mem_match) ||
                   (i_id_ex_memread && w_id_ex_match)) begin
         o_need = NEED_ONE;
      end
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: merges hazard stalls, cache freezes and redirect
// flushes into stage enables. Define HAZARD_PERF_CNT_EN to add perf counters.
module hazard_controller
   import hazard_controller_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_branch,
   input  logic              id_jalr,
   input  logic              id_redirect,
   input  logic [REG_AW-1:0] id_ex_rd,
   input  logic              id_ex_regwrite,
   input  logic              id_ex_memread,
   input  logic [REG_AW-1:0] ex_mem_rd,
   input  logic              ex_mem_memread,
   input  logic              icache_stall,
   input  logic              dcache_stall,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              ex_mem_write,
   output logic              mem_wb_write,
   output logic              busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0] perf_stall_cycles,
   output logic [PERF_W-1:0] perf_freeze_cycles,
   output logic [PERF_W-1:0] perf_flushes
`endif
);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_cnt_dec;
   logic               r_pend_flush;
   logic               w_pend_flush_nxt;
   logic [NEED_W-1:0]  w_need;
   logic               w_freeze;
   logic               w_stall;
   logic               w_flush_evt;

   hazard_detect u_hazard_detect (
      .i_id_rs1         (id_rs1),
      .i_id_rs2         (id_rs2),
      .i_id_use_rs1     (id_use_rs1),
      .i_id_use_rs2     (id_use_rs2),
      .i_id_branch      (id_branch),
      .i_id_jalr        (id_jalr),
      .i_id_ex_rd       (id_ex_rd),
      .i_id_ex_regwrite (id_ex_regwrite),
      .i_id_ex_memread  (id_ex_memread),
      .i_ex_mem_rd      (ex_mem_rd),
      .i_ex_mem_memread (ex_mem_memread),
      .o_need           (w_need)
   );

   assign w_freeze  = icache_stall | dcache_stall;
   assign w_cnt_dec = r_cnt - CNT_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= RUN;
         r_cnt        <= '0;
         r_pend_flush <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_pend_flush <= w_pend_flush_nxt;
      end
   end

   // Priority: reset > cache freeze > hazard stall > redirect flush
   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt;
      w_pend_flush_nxt = r_pend_flush;
      pc_write         = 1'b1;
      if_id_write      = 1'b1;
      if_id_flush      = 1'b0;
      id_ex_flush      = 1'b0;
      ex_mem_write     = 1'b1;
      mem_wb_write     = 1'b1;
      busy             = 1'b0;
      w_stall          = 1'b0;
      w_flush_evt      = 1'b0;

      if (rst) begin
         pc_write         = 1'b0;
         if_id_write      = 1'b0;
         if_id_flush      = 1'b1;
         id_ex_flush      = 1'b1;
         ex_mem_write     = 1'b0;
         mem_wb_write     = 1'b0;
         busy             = 1'b1;
         w_state_nxt      = RUN;
         w_cnt_nxt        = '0;
         w_pend_flush_nxt = 1'b0;
      end else if (w_freeze) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         busy         = (r_state != RUN);
         // A redirect seen while frozen is remembered and applied on thaw
         if (id_redirect) begin
            w_pend_flush_nxt = 1'b1;
         end
      end else begin
         case (r_state)
            RUN: begin
               if (w_need != NEED_NONE) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
                  busy        = 1'b1;
                  w_stall     = 1'b1;
                  if (w_need == NEED_TWO) begin
                     w_state_nxt = STALL;
                     w_cnt_nxt   = CNT_W'(1);
                  end
               end else begin
                  if_id_flush      = id_redirect | r_pend_flush;
                  w_flush_evt      = id_redirect | r_pend_flush;
                  w_pend_flush_nxt = 1'b0;
               end
            end
            STALL: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
               busy        = 1'b1;
               w_stall     = 1'b1;
               w_cnt_nxt   = w_cnt_dec;
               if (w_cnt_dec == '0) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               w_state_nxt = RUN;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] r_perf_stall;
   logic [PERF_W-1:0] r_perf_freeze;
   logic [PERF_W-1:0] r_perf_flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_stall  <= '0;
         r_perf_freeze <= '0;
         r_perf_flush  <= '0;
      end else begin
         if (w_stall)     r_perf_stall  <= r_perf_stall + PERF_W'(1);
         if (w_freeze)    r_perf_freeze <= r_perf_freeze + PERF_W'(1);
         if (w_flush_evt) r_perf_flush  <= r_perf_flush + PERF_W'(1);
      end
   end

   assign perf_stall_cycles  = r_perf_stall;
   assign perf_freeze_cycles = r_perf_freeze;
   assign perf_flushes       = r_perf_flush;
`endif

endmodule
